// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low glyph constants (bit 0 = a .. bit 6 = g),
// the blank pattern, and the output-frame state encoding.
package seg7_pkg;

  localparam logic [6:0] SEG_GLYPH_0 = 7'b1000000;
  localparam logic [6:0] SEG_GLYPH_1 = 7'b1111001;
  localparam logic [6:0] SEG_GLYPH_2 = 7'b0100100;
  localparam logic [6:0] SEG_GLYPH_3 = 7'b0110000;
  localparam logic [6:0] SEG_GLYPH_4 = 7'b0011001;
  localparam logic [6:0] SEG_GLYPH_5 = 7'b0010010;
  localparam logic [6:0] SEG_GLYPH_6 = 7'b0000010;
  localparam logic [6:0] SEG_GLYPH_7 = 7'b1111000;
  localparam logic [6:0] SEG_GLYPH_8 = 7'b0000000;
  localparam logic [6:0] SEG_GLYPH_9 = 7'b0010000;
  localparam logic [6:0] SEG_GLYPH_A = 7'b0001000;
  localparam logic [6:0] SEG_GLYPH_B = 7'b0000011;
  localparam logic [6:0] SEG_GLYPH_C = 7'b1000110;
  localparam logic [6:0] SEG_GLYPH_D = 7'b0100001;
  localparam logic [6:0] SEG_GLYPH_E = 7'b0000110;
  localparam logic [6:0] SEG_GLYPH_F = 7'b0001110;
  localparam logic [6:0] SEG_BLANK   = 7'b1111111;

  localparam int unsigned SEG_CNT_W = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // Nibble -> glyph, for the hex encoder side of the codebase.
  function automatic logic [6:0] seg7_encode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = SEG_GLYPH_0;
      4'h1:    pat = SEG_GLYPH_1;
      4'h2:    pat = SEG_GLYPH_2;
      4'h3:    pat = SEG_GLYPH_3;
      4'h4:    pat = SEG_GLYPH_4;
      4'h5:    pat = SEG_GLYPH_5;
      4'h6:    pat = SEG_GLYPH_6;
      4'h7:    pat = SEG_GLYPH_7;
      4'h8:    pat = SEG_GLYPH_8;
      4'h9:    pat = SEG_GLYPH_9;
      4'hA:    pat = SEG_GLYPH_A;
      4'hB:    pat = SEG_GLYPH_B;
      4'hC:    pat = SEG_GLYPH_C;
      4'hD:    pat = SEG_GLYPH_D;
      4'hE:    pat = SEG_GLYPH_E;
      4'hF:    pat = SEG_GLYPH_F;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_lookup.sv
// Combinational glyph decoder: 7-bit active-low pattern -> hex nibble plus invalid flag.
module seg7_lookup
  import seg7_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] nibble,
  output logic       invalid
);

  // Anything that is not one of the 16 hex glyphs (blank included) decodes to 0 and flags.
  always_comb begin
    nibble  = 4'h0;
    invalid = 1'b0;
    case (pat)
      SEG_GLYPH_0: nibble = 4'h0;
      SEG_GLYPH_1: nibble = 4'h1;
      SEG_GLYPH_2: nibble = 4'h2;
      SEG_GLYPH_3: nibble = 4'h3;
      SEG_GLYPH_4: nibble = 4'h4;
      SEG_GLYPH_5: nibble = 4'h5;
      SEG_GLYPH_6: nibble = 4'h6;
      SEG_GLYPH_7: nibble = 4'h7;
      SEG_GLYPH_8: nibble = 4'h8;
      SEG_GLYPH_9: nibble = 4'h9;
      SEG_GLYPH_A: nibble = 4'hA;
      SEG_GLYPH_B: nibble = 4'hB;
      SEG_GLYPH_C: nibble = 4'hC;
      SEG_GLYPH_D: nibble = 4'hD;
      SEG_GLYPH_E: nibble = 4'hE;
      SEG_GLYPH_F: nibble = 4'hF;
      default: begin
        nibble  = 4'h0;
        invalid = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg7_decoder.sv
// Multiplexed seven-segment capture: debounces each digit's pattern, decodes it on a stable
// run, and hands complete frames to a valid/ready consumer.
module seg7_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg_in,
  input  logic [2:0]              dig_idx,
  input  logic                    seg_valid,
  output logic [4*NUM_DIGITS-1:0] out_word,
  output logic [NUM_DIGITS-1:0]   out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam logic [SEG_CNT_W-1:0] STABLE_C = SEG_CNT_W'(STABLE_CYCLES);
  localparam logic [3:0]           NDIG_C   = 4'(NUM_DIGITS);

  logic [6:0]              last_pat_r [NUM_DIGITS];
  logic [SEG_CNT_W-1:0]    cnt_r      [NUM_DIGITS];
  logic [SEG_CNT_W-1:0]    cnt_nxt_s  [NUM_DIGITS];
  logic [4*NUM_DIGITS-1:0] value_r;
  logic [NUM_DIGITS-1:0]   err_r;
  logic [NUM_DIGITS-1:0]   got_r;
  logic [NUM_DIGITS-1:0]   hit_s;
  logic [NUM_DIGITS-1:0]   same_s;
  logic [NUM_DIGITS-1:0]   commit_s;
  logic                    sample_ok_s;
  logic                    load_s;
  logic [3:0]              dec_nib_s;
  logic                    dec_inv_s;
  out_state_e              state_r;

  seg7_lookup u_lookup (
    .pat     (seg_in),
    .nibble  (dec_nib_s),
    .invalid (dec_inv_s)
  );

  assign sample_ok_s = seg_valid && ({1'b0, dig_idx} < NDIG_C);
  assign load_s      = (&got_r) && ((state_r == ST_EMPTY) || out_ready);

  // Per-digit run counting; commit only on the sample that reaches STABLE_CYCLES exactly.
  always_comb begin
    hit_s     = '0;
    same_s    = '0;
    commit_s  = '0;
    cnt_nxt_s = '{default: '0};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      hit_s[i]  = sample_ok_s && (dig_idx == 3'(i));
      same_s[i] = (seg_in == last_pat_r[i]);
      if (same_s[i]) begin
        if (cnt_r[i] == STABLE_C) begin
          cnt_nxt_s[i] = STABLE_C;
        end else begin
          cnt_nxt_s[i] = cnt_r[i] + SEG_CNT_W'(1);
        end
      end else begin
        cnt_nxt_s[i] = SEG_CNT_W'(1);
      end
      commit_s[i] = hit_s[i] && (cnt_nxt_s[i] == STABLE_C) &&
                    !(same_s[i] && (cnt_r[i] == STABLE_C));
    end
  end

  // Digit capture registers; a commit's got-set wins over a same-cycle frame-load clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        last_pat_r[i] <= SEG_BLANK;
        cnt_r[i]      <= '0;
      end
      value_r <= '0;
      err_r   <= '0;
      got_r   <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (hit_s[i]) begin
          last_pat_r[i] <= seg_in;
          cnt_r[i]      <= cnt_nxt_s[i];
        end
        if (commit_s[i]) begin
          value_r[4*i +: 4] <= dec_nib_s;
          err_r[i]          <= dec_inv_s;
          got_r[i]          <= 1'b1;
        end else if (load_s) begin
          got_r[i] <= 1'b0;
        end
      end
    end
  end

  // Output frame FSM; out_word/out_err only change on a load edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_EMPTY;
      out_word  <= '0;
      out_err   <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (load_s) begin
            state_r   <= ST_FULL;
            out_word  <= value_r;
            out_err   <= err_r;
            out_valid <= 1'b1;
          end else begin
            out_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          if (load_s) begin
            out_word  <= value_r;
            out_err   <= err_r;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            state_r   <= ST_EMPTY;
            out_valid <= 1'b0;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: begin
          state_r   <= ST_EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_decoder.sv
// Directed bench for seg7_decoder with NUM_DIGITS=4, STABLE_CYCLES=4.
module tb_seg7_decoder;

  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100, G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001, G5 = 7'b0010010, G6 = 7'b0000010, G7 = 7'b1111000;
  localparam logic [6:0] G8 = 7'b0000000, G9 = 7'b0010000, GA = 7'b0001000, GB = 7'b0000011;
  localparam logic [6:0] GC = 7'b1000110, GD = 7'b0100001, GE = 7'b0000110, GF = 7'b0001110;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  seg_in = 7'h7F;
  logic [2:0]  dig_idx = 3'd0;
  logic        seg_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] out_word;
  logic [3:0]  out_err;
  logic        out_valid;

  int checks = 0;
  int errors = 0;

  seg7_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .seg_in    (seg_in),
    .dig_idx   (dig_idx),
    .seg_valid (seg_valid),
    .out_word  (out_word),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] idx, input logic [6:0] pat, input int n);
    for (int k = 0; k < n; k++) begin
      dig_idx   = idx;
      seg_in    = pat;
      seg_valid = 1'b1;
      tick();
    end
    seg_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [6:0] p0, input logic [6:0] p1,
                            input logic [6:0] p2, input logic [6:0] p3);
    send(3'd0, p0, 4);
    send(3'd1, p1, 4);
    send(3'd2, p2, 4);
    send(3'd3, p3, 4);
  endtask

  // Reset held for one cycle with a live sample present; that sample must be discarded.
  task automatic pulse_reset();
    reset     = 1'b1;
    dig_idx   = 3'd0;
    seg_in    = G1;
    seg_valid = 1'b1;
    tick();
    reset     = 1'b0;
    seg_valid = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (out_word !== 16'h0000) begin errors++; $display("FAIL reset_word got %h exp 0000", out_word); end
    checks++; if (out_err !== 4'b0000) begin errors++; $display("FAIL reset_err got %b exp 0000", out_err); end
  endtask

  task automatic test_basic();
    send_frame(G1, G2, G3, G4);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_t1_valid got %b exp 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_t2_valid got %b exp 1", out_valid); end
    checks++; if (out_word !== 16'h4321) begin errors++; $display("FAIL basic_word got %h exp 4321", out_word); end
    checks++; if (out_err !== 4'b0000) begin errors++; $display("FAIL basic_err got %b exp 0000", out_err); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_consume got %b exp 0", out_valid); end
  endtask

  task automatic test_ignored_idx();
    logic [6:0] pats [4];
    pats = '{G1, G2, G3, G4};
    pulse_reset();
    for (int d = 0; d < 4; d++) begin
      send(3'(d), pats[d], 2);
      send(3'd4, G8, 1);
      send(3'd5, G8, 1);
      send(3'd7, GE, 1);
      send(3'(d), pats[d], 2);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ign_t1_valid got %b exp 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ign_t2_valid got %b exp 1", out_valid); end
    checks++; if (out_word !== 16'h4321) begin errors++; $display("FAIL ign_word got %h exp 4321", out_word); end
    checks++; if (out_err !== 4'b0000) begin errors++; $display("FAIL ign_err got %b exp 0000", out_err); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_blank_err();
    send_frame(G8, BLANK, G7, G9);
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL blank_valid got %b exp 1", out_valid); end
    checks++; if (out_word !== 16'h9708) begin errors++; $display("FAIL blank_word got %h exp 9708", out_word); end
    checks++; if (out_err !== 4'b0010) begin errors++; $display("FAIL blank_err got %b exp 0010", out_err); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_interrupted();
    send(3'd0, GA, 4);
    send(3'd1, GB, 4);
    send(3'd3, GC, 4);
    send(3'd2, G2, 3);
    send(3'd2, G3, 1);
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL intr_no_commit got %b exp 0", out_valid); end
    send(3'd2, G3, 4);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL intr_valid got %b exp 1", out_valid); end
    checks++; if (out_word !== 16'hC3BA) begin errors++; $display("FAIL intr_word got %h exp C3BA", out_word); end
    checks++; if (out_err !== 4'b0000) begin errors++; $display("FAIL intr_err got %b exp 0000", out_err); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL intr_consume got %b exp 0", out_valid); end
  endtask

  task automatic test_backpressure();
    send_frame(G5, G6, GE, GF);
    tick();
    checks++; if (out_word !== 16'hFE65) begin errors++; $display("FAIL bp_first_word got %h exp FE65", out_word); end
    send_frame(G0, G9, G8, G7);
    send(3'd0, GD, 4);
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cyc %0d got %b exp 1", c, out_valid); end
      checks++; if (out_word !== 16'hFE65) begin errors++; $display("FAIL bp_hold_word cyc %0d got %h exp FE65", c, out_word); end
    end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_reload_valid got %b exp 1", out_valid); end
    checks++; if (out_word !== 16'h789D) begin errors++; $display("FAIL bp_reload_word got %h exp 789D", out_word); end
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_reset_midframe();
    send(3'd0, G1, 4);
    send(3'd1, G2, 4);
    send(3'd2, G3, 4);
    pulse_reset();
    checks++; if (out_word !== 16'h0000) begin errors++; $display("FAIL rst_word got %h exp 0000", out_word); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", out_valid); end
    send(3'd3, G4, 4);
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_partial cyc %0d got %b exp 0", c, out_valid); end
    end
    send(3'd0, G1, 4);
    send(3'd1, G2, 4);
    send(3'd2, G3, 4);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_t1_valid got %b exp 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_t2_valid got %b exp 1", out_valid); end
    checks++; if (out_word !== 16'h4321) begin errors++; $display("FAIL rst_word2 got %h exp 4321", out_word); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // Digit 0 commits a new glyph on the very edge the frame loads.
  task automatic test_back_to_back();
    send(3'd0, G5, 4);
    send(3'd1, G6, 4);
    send(3'd2, G7, 4);
    send(3'd0, G8, 3);
    send(3'd3, G9, 4);
    send(3'd0, G8, 1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b exp 1", out_valid); end
    checks++; if (out_word !== 16'h9765) begin errors++; $display("FAIL b2b_word got %h exp 9765", out_word); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_consume got %b exp 0", out_valid); end
    send(3'd1, GA, 4);
    send(3'd2, GB, 4);
    send(3'd3, GC, 4);
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_second_valid got %b exp 1", out_valid); end
    checks++; if (out_word !== 16'hCBA8) begin errors++; $display("FAIL b2b_second_word got %h exp CBA8", out_word); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignored_idx();
    test_blank_err();
    test_interrupted();
    test_backpressure();
    test_reset_midframe();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_decoder.md
SEG7_DECODER -- requirements
Module: seg7_decoder

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 Parameter STABLE_CYCLES, default 4, consecutive identical samples needed to commit a digit (1..15).
REQ-003 Clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 seg_in  input  7  active-low segment pattern, bit 0 = segment a through bit 6 = segment g.
REQ-006 dig_idx  input  3  index of the digit that seg_in belongs to.
REQ-007 seg_valid  input  1  sample strobe; seg_in/dig_idx are sampled only while high.
REQ-008 out_word  output  4*NUM_DIGITS  decoded nibbles; digit i occupies bits [4i+3:4i].
REQ-009 out_err  output  NUM_DIGITS  per-digit flag: committed pattern was not a legal glyph.
REQ-010 out_valid  output  1  out_word/out_err hold a complete, unconsumed frame.
REQ-011 out_ready  input  1  consumer accepts the frame when high together with out_valid.

Function
REQ-012 Legal glyphs (seg_in, binary g..a) SHALL decode as: 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9, 0001000=A, 0000011=b, 1000110=C, 0100001=d, 0000110=E, 0001110=F.
REQ-013 Any other pattern, including blank 1111111, SHALL decode to nibble 0 with the invalid flag set.
REQ-014 Per digit the block SHALL hold last_pat (7b), cnt (saturating 0..STABLE_CYCLES), value (4b), err (1b), got (1b).
REQ-015 Sample with seg_in == last_pat[dig_idx]: cnt increments, saturating at STABLE_CYCLES.
REQ-016 Sample with seg_in != last_pat[dig_idx]: last_pat <= seg_in, cnt <= 1.
REQ-017 Commit SHALL occur on the sample that brings cnt to exactly STABLE_CYCLES (including a new pattern when STABLE_CYCLES = 1): value/err <= decode(seg_in), got <= 1; further identical samples SHALL NOT recommit.
REQ-018 Samples with dig_idx >= NUM_DIGITS SHALL be ignored entirely.
REQ-019 Output is a two-state FSM: EMPTY (out_valid=0), FULL (out_valid=1).
REQ-020 Frame load condition: all got bits set AND (state EMPTY OR out_ready=1); on load, out_word/out_err <= registered value/err, got bits cleared, state FULL.
REQ-021 FULL with out_ready=1 and no load -> EMPTY; FULL with out_ready=0 -> hold out_word/out_err/out_valid stable.
REQ-022 Latency: commit of the last outstanding digit in cycle t sets got at end of t; frame loads at end of t+1; out_valid high from t+2.
REQ-023 While a completed frame waits (got all set, FULL, out_ready=0), further commits SHALL update value/err (latest wins); loaded frame reflects values at the load edge.
REQ-024 Commit and load in the same cycle: load uses pre-commit registered value; got for the committing digit SHALL end set (set overrides clear).
REQ-025 No frame is ever dropped or duplicated: each load follows at least one fresh commit of every digit.

Reset
REQ-026 Reset SHALL force: last_pat = 1111111, cnt = 0, value = 0, err = 0, got = 0, state EMPTY, out_valid = 0, out_word = 0, out_err = 0.
REQ-027 Reset asserted mid-collection or with a frame pending SHALL discard all partial and pending data; first frame after reset requires fresh commits of all digits.
REQ-028 Inputs sampled in a cycle with Reset high SHALL have no effect.

Structure
REQ-029 Package seg7_pkg SHALL hold the 16 glyph constants, the blank constant, and the output FSM state enum, shared with the existing hex encoder users.
REQ-030 Sub-module seg7_lookup (combinational: 7b pattern -> 4b nibble + invalid) SHALL implement REQ-012/013 and be instantiated once on seg_in.

Verification
REQ-031 Defaults; digits 0..3 each sent 4 samples of glyphs 1,2,3,4 (0100100 etc.) -> out_word=16'h4321, out_err=0, out_valid 2 cycles after last sample.
REQ-032 Digit 2 sent 3x 0100100 then 1x 0110000 then 4x 0110000 -> digit 2 commits 3, never 2; no commit on the interrupted run.
REQ-033 Digit 1 sent 4x 1111111 with others legal -> out_err=4'b0010, nibble 1 = 0.
REQ-034 Frame FULL, out_ready=0 for 20 cycles while new frame completes -> out_word unchanged; raise out_ready -> second frame loads same edge, out_valid stays high.
REQ-035 Reset pulsed after 3 of 4 digits committed -> out_valid stays 0 until all 4 digits recommit.
REQ-036 Samples with dig_idx=5 (NUM_DIGITS=4) interleaved -> no state change, frame identical to REQ-031.
